// File: rtl/dff_chk_pkg.sv
// rtl/dff_chk_pkg.sv - shared state type and limits for the D flip-flop response checker
package dff_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  localparam int LAT_MAX = 8;
  localparam int FILL_W  = $clog2(LAT_MAX);

  // Terminal value of the fill counter for a given latency (counter runs 0..latency-1).
  function automatic logic [FILL_W-1:0] fill_last(input int latency);
    return FILL_W'(latency - 1);
  endfunction

endpackage

// File: rtl/dff_chk_dly_line.sv
// rtl/dff_chk_dly_line.sv - DEPTH-deep stimulus delay line; tap is d from DEPTH edges ago
module dff_chk_dly_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic tap
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign tap = sr_q[DEPTH-1];

endmodule

// File: rtl/dff_response_checker.sv
// rtl/dff_response_checker.sv - compares q against d delayed by LATENCY over a programmed window
module dff_response_checker
  import dff_chk_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] chk_len,
  input  logic             d,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_flag,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [FILL_W-1:0] FILL_LAST = fill_last(LATENCY);

  chk_state_t        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  samples_q, samples_d;
  logic [CNT_W-1:0]  errors_q, errors_d;
  logic [CNT_W-1:0]  first_q, first_d;
  logic              err_q, err_d;
  logic              pass_q, pass_d;
  logic              tap;
  logic              mismatch;

  dff_chk_dly_line #(
    .DEPTH(LATENCY)
  ) u_dly (
    .clk(clk),
    .rst(rst),
    .d  (d),
    .tap(tap)
  );

  assign mismatch = q ^ tap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      len_q     <= '0;
      samples_q <= '0;
      errors_q  <= '0;
      first_q   <= '0;
      err_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      len_q     <= len_d;
      samples_q <= samples_d;
      errors_q  <= errors_d;
      first_q   <= first_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    len_d     = len_q;
    samples_d = samples_q;
    errors_d  = errors_q;
    first_d   = first_q;
    err_d     = err_q;
    pass_d    = pass_q;

    if (clr) begin
      state_d   = IDLE;
      fill_d    = '0;
      samples_d = '0;
      errors_d  = '0;
      first_d   = '0;
      err_d     = 1'b0;
      pass_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d   = FILL;
            fill_d    = '0;
            len_d     = chk_len;
            samples_d = '0;
            errors_d  = '0;
            first_d   = '0;
            err_d     = 1'b0;
            pass_d    = 1'b0;
          end
        end
        FILL: begin
          if (!en) begin
            state_d = IDLE;
          end else if (fill_q == FILL_LAST) begin
            if (len_q == '0) begin
              state_d = DONE;
              pass_d  = (errors_q == '0);
            end else begin
              state_d = CHECK;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        CHECK: begin
          if (!en) begin
            state_d = IDLE;
          end else begin
            samples_d = samples_q + 1'b1;
            if (mismatch) begin
              if (errors_q != '1) begin
                errors_d = errors_q + 1'b1;
              end
              err_d = 1'b1;
              if (!err_q) begin
                first_d = samples_q;
              end
            end
            // pass uses the post-update error count so a final-compare miss fails the run
            if (samples_d == len_q) begin
              state_d = DONE;
              pass_d  = (errors_d == '0);
            end
          end
        end
        DONE: begin
          if (!en) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy          = (state_q == FILL) || (state_q == CHECK);
  assign done          = (state_q == DONE);
  assign pass          = pass_q;
  assign err_flag      = err_q;
  assign samples       = samples_q;
  assign errors        = errors_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// tb/tb_dff_response_checker.sv - self-checking bench for dff_response_checker
module tb_dff_response_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        d   = 1'b0;
  logic        q   = 1'b0;
  logic        en_a = 1'b0, en_l = 1'b0, en_s = 1'b0;
  logic [15:0] len_a = '0, len_l = '0;
  logic [3:0]  len_s = '0;

  logic        busy_a, done_a, pass_a, err_a;
  logic [15:0] smp_a, errs_a, first_a;
  logic        busy_l, done_l, pass_l, err_l;
  logic [15:0] smp_l, errs_l, first_l;
  logic        busy_s, done_s, pass_s, err_s;
  logic [3:0]  smp_s, errs_s, first_s;

  always #5 clk = ~clk;

  dff_response_checker #(.CNT_W(16), .LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .en(en_a), .clr(clr), .chk_len(len_a), .d(d), .q(q),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_flag(err_a),
    .samples(smp_a), .errors(errs_a), .first_err_idx(first_a)
  );

  dff_response_checker #(.CNT_W(16), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .en(en_l), .clr(clr), .chk_len(len_l), .d(d), .q(q),
    .busy(busy_l), .done(done_l), .pass(pass_l), .err_flag(err_l),
    .samples(smp_l), .errors(errs_l), .first_err_idx(first_l)
  );

  dff_response_checker #(.CNT_W(4), .LATENCY(1)) u_sat (
    .clk(clk), .rst(rst), .en(en_s), .clr(clr), .chk_len(len_s), .d(d), .q(q),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_flag(err_s),
    .samples(smp_s), .errors(errs_s), .first_err_idx(first_s)
  );

  int cur = 0;
  logic        o_busy, o_done, o_pass, o_err;
  logic [15:0] o_smp, o_errs, o_first;

  always_comb begin
    o_busy = busy_a; o_done = done_a; o_pass = pass_a; o_err = err_a;
    o_smp = smp_a; o_errs = errs_a; o_first = first_a;
    case (cur)
      1: begin
        o_busy = busy_l; o_done = done_l; o_pass = pass_l; o_err = err_l;
        o_smp = smp_l; o_errs = errs_l; o_first = first_l;
      end
      2: begin
        o_busy = busy_s; o_done = done_s; o_pass = pass_s; o_err = err_s;
        o_smp = {12'd0, smp_s}; o_errs = {12'd0, errs_s}; o_first = {12'd0, first_s};
      end
      default: ;
    endcase
  end

  typedef struct {
    int          inst;
    int          lat;
    logic [15:0] len;
    logic [31:0] dpat;
    logic [31:0] flip;
    bit          stuck;
    logic [15:0] e_smp;
    logic [15:0] e_errs;
    logic [15:0] e_first;
    bit          e_pass;
    int          e_edge;
  } vec_t;

  typedef struct {
    logic [15:0] smp;
    logic [15:0] errs;
    logic [15:0] first;
    bit          pass;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_en(input int inst, input logic v);
    case (inst)
      1: en_l = v;
      2: en_s = v;
      default: en_a = v;
    endcase
  endtask

  task automatic set_len(input int inst, input logic [15:0] v);
    case (inst)
      1: len_l = v;
      2: len_s = v[3:0];
      default: len_a = v;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] dh;
    bit          seen;
    int          k;
    exp_t        ex;
    dh   = '0;
    seen = 1'b0;
    cur  = v.inst;
    @(negedge clk);
    set_len(v.inst, v.len);
    set_en(v.inst, 1'b1);
    d = 1'b0;
    q = 1'b0;
    sb.push_back('{v.e_smp, v.e_errs, v.e_first, v.e_pass, v.e_edge});
    tick();
    for (int c = 1; c <= 80 && !seen; c++) begin
      @(negedge clk);
      set_len(v.inst, ~v.len);
      if (c - 1 < 32) begin
        d = v.dpat[c-1];
        dh[c-1] = d;
      end else begin
        d = 1'b0;
      end
      k = c - v.lat - 1;
      if (k >= 0 && k < 32) q = v.stuck ? 1'b0 : (dh[k] ^ v.flip[k]);
      else q = 1'b0;
      tick();
      if (o_done) begin
        seen = 1'b1;
        ex = sb.pop_front();
        check($sformatf("v%0d_done_edge", idx), c, ex.edge_n);
        check($sformatf("v%0d_samples", idx), o_smp, ex.smp);
        check($sformatf("v%0d_errors", idx), o_errs, ex.errs);
        check($sformatf("v%0d_pass", idx), o_pass, ex.pass);
        check($sformatf("v%0d_err_flag", idx), o_err, ex.errs != 0);
        if (ex.errs != 0) check($sformatf("v%0d_first_idx", idx), o_first, ex.first);
        check($sformatf("v%0d_busy_at_done", idx), o_busy, 0);
      end else if (c == 1) begin
        check($sformatf("v%0d_busy_fill", idx), o_busy, 1);
      end
    end
    if (!seen) begin
      void'(sb.pop_front());
      check($sformatf("v%0d_done_timeout", idx), 0, 1);
    end
    @(negedge clk);
    set_en(v.inst, 1'b0);
    tick();
    check($sformatf("v%0d_done_fall", idx), o_done, 0);
    check($sformatf("v%0d_pass_hold", idx), o_pass, v.e_pass);
  endtask

  task automatic wait_samples(input logic [15:0] target, input string name);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      d = 1'b0;
      q = 1'b1;
      tick();
      if (o_smp == target) hit = 1'b1;
    end
    if (!hit) check(name, 0, 1);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 1, 16'd8,  32'h0000_00B2, 32'h0,   1'b0, 16'd8,  16'd0, 16'd0, 1'b1, 9};
    tbl[1] = '{0, 1, 16'd4,  32'hFFFF_FFFF, 32'h0,   1'b1, 16'd4,  16'd4, 16'd0, 1'b0, 5};
    tbl[2] = '{0, 1, 16'd6,  32'h0000_00A5, 32'h8,   1'b0, 16'd6,  16'd1, 16'd3, 1'b0, 7};
    tbl[3] = '{0, 1, 16'd0,  32'h0000_0000, 32'h0,   1'b0, 16'd0,  16'd0, 16'd0, 1'b1, 1};
    tbl[4] = '{1, 3, 16'd5,  32'h0000_0013, 32'h11,  1'b0, 16'd5,  16'd2, 16'd0, 1'b0, 8};
    tbl[5] = '{1, 3, 16'd0,  32'h0000_0000, 32'h0,   1'b0, 16'd0,  16'd0, 16'd0, 1'b1, 3};
    tbl[6] = '{0, 1, 16'd3,  32'h0000_0005, 32'h4,   1'b0, 16'd3,  16'd1, 16'd2, 1'b0, 4};
    tbl[7] = '{0, 1, 16'd10, 32'h0000_036C, 32'h2A4, 1'b0, 16'd10, 16'd4, 16'd2, 1'b0, 11};

    cur = 0;
    #2;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_pass", o_pass, 0);
    check("rst_err_flag", o_err, 0);
    check("rst_samples", o_smp, 0);
    check("rst_errors", o_errs, 0);
    check("rst_first", o_first, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // asynchronous reset in the middle of CHECK
    cur = 0;
    @(negedge clk);
    len_a = 16'd8;
    en_a = 1'b1;
    tick();
    wait_samples(16'd5, "rstmid_timeout");
    @(negedge clk);
    #2;
    rst  = 1'b0;
    en_a = 1'b0;
    #1;
    check("rstmid_busy", o_busy, 0);
    check("rstmid_samples", o_smp, 0);
    check("rstmid_errors", o_errs, 0);
    check("rstmid_err_flag", o_err, 0);
    check("rstmid_done", o_done, 0);
    @(negedge clk);
    rst = 1'b1;

    // abort by dropping en at sample 2
    @(negedge clk);
    len_a = 16'd8;
    en_a = 1'b1;
    tick();
    wait_samples(16'd2, "abort_timeout");
    @(negedge clk);
    en_a = 1'b0;
    tick();
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_samples", o_smp, 2);
    check("abort_pass", o_pass, 0);

    // clr wins over en in IDLE, and clears a run in progress
    @(negedge clk);
    en_a = 1'b1;
    clr  = 1'b1;
    tick();
    check("clr_en_idle_busy", o_busy, 0);
    check("clr_en_samples", o_smp, 0);
    @(negedge clk);
    clr = 1'b0;
    tick();
    check("clr_release_busy", o_busy, 1);
    @(negedge clk);
    clr = 1'b1;
    tick();
    check("clr_fill_busy", o_busy, 0);
    @(negedge clk);
    clr  = 1'b0;
    en_a = 1'b0;

    // narrow counters: 20 forced mismatches against a 15-compare window
    cur = 2;
    @(negedge clk);
    len_s = 4'd15;
    en_s  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      d = 1'b1;
      q = 1'b0;
    end
    tick();
    check("sat_errors", o_errs, 15);
    check("sat_samples", o_smp, 15);
    check("sat_done", o_done, 1);
    check("sat_pass", o_pass, 0);
    check("sat_first", o_first, 0);
    @(negedge clk);
    en_s = 1'b0;
    tick();

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
